accum_table_drain: RTL and testbench

ACCUM_TABLE_DRAIN -- requirements
Module: accum_table_drain

---
 rtl/tpu_accum_pkg.sv | 38 +++
 rtl/accum_drain_skid.sv | 98 +++++++++
 rtl/accum_table_drain.sv | 165 ++++++++++++++++
 tb/tb_accum_table_drain.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_accum_pkg.sv
// tpu_accum_pkg
//   Shared definitions for the accumulator-table blocks (drain, write and
//   read controllers): default geometry, width helpers and the drain FSM
//   state type.
//   No ports; imported with "import tpu_accum_pkg::*;".
package tpu_accum_pkg;

  localparam int DEF_DATA_WIDTH   = 8;
  localparam int DEF_MAX_OUT_ROWS = 128;
  localparam int DEF_MAX_OUT_COLS = 128;
  localparam int DEF_SYS_ARR_ROWS = 16;
  localparam int DEF_SYS_ARR_COLS = 16;

  // Word address width of one table lane: every output row of every
  // column-block owns one word.
  function automatic int addrWidthOf(input int outRows, input int outCols,
                                     input int arrCols);
    return $clog2(outRows * (outCols / arrCols));
  endfunction

  // Width of a submatrix index along one dimension.
  function automatic int blockIdxWidthOf(input int total, input int perBlock);
    return $clog2(total / perBlock);
  endfunction

  // Width of a row index inside one submatrix.
  function automatic int rowIdxWidthOf(input int arrRows);
    return $clog2(arrRows);
  endfunction

  typedef enum logic [1:0] {
    DRAIN_IDLE  = 2'd0,
    DRAIN_READ  = 2'd1,
    DRAIN_FLUSH = 2'd2,
    DRAIN_DONE  = 2'd3
  } drain_state_e;

endpackage

// File: rtl/accum_drain_skid.sv
// accum_drain_skid
//   Two-entry output buffer for the drain row stream. Each entry holds the
//   row data, its row index and the last-row flag. The head entry drives the
//   outputs directly, so they only change when the head is popped.
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_push, i_data,       write one entry (caller guarantees space)
//   i_row, i_last
//   i_ready               consumer ready; pop happens on o_valid & i_ready
//   o_valid, o_data,      head entry
//   o_row, o_last
//   o_count               entries currently held (0..2)
module accum_drain_skid
  import tpu_accum_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_WIDTH * DEF_SYS_ARR_COLS,
  parameter int ROW_W  = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ROW_W-1:0]  i_row,
  input  logic              i_last,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [ROW_W-1:0]  o_row,
  output logic              o_last,
  output logic [1:0]        o_count
);

  logic [1:0]        r_count;
  logic [DATA_W-1:0] r_head_data, r_tail_data;
  logic [ROW_W-1:0]  r_head_row, r_tail_row;
  logic              r_head_last, r_tail_last;
  logic              w_pop;

  assign w_pop   = i_ready && (r_count != 2'd0);
  assign o_valid = (r_count != 2'd0);
  assign o_data  = r_head_data;
  assign o_row   = r_head_row;
  assign o_last  = r_head_last;
  assign o_count = r_count;

  // Head/tail shift register. A push lands in the head when it would
  // otherwise be empty after this cycle, else in the tail; a pop promotes
  // the tail into the head.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count     <= 2'd0;
      r_head_data <= '0;
      r_tail_data <= '0;
      r_head_row  <= '0;
      r_tail_row  <= '0;
      r_head_last <= 1'b0;
      r_tail_last <= 1'b0;
    end else begin
      case ({i_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) begin
            r_head_data <= i_data;
            r_head_row  <= i_row;
            r_head_last <= i_last;
          end else begin
            r_tail_data <= i_data;
            r_tail_row  <= i_row;
            r_tail_last <= i_last;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_head_data <= r_tail_data;
          r_head_row  <= r_tail_row;
          r_head_last <= r_tail_last;
          r_count     <= r_count - 2'd1;
        end
        2'b11: begin
          if (r_count == 2'd1) begin
            r_head_data <= i_data;
            r_head_row  <= i_row;
            r_head_last <= i_last;
          end else begin
            r_head_data <= r_tail_data;
            r_head_row  <= r_tail_row;
            r_head_last <= r_tail_last;
            r_tail_data <= i_data;
            r_tail_row  <= i_row;
            r_tail_last <= i_last;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: rtl/accum_table_drain.sv
// accum_table_drain
//   Reads one submatrix (up to SYS_ARR_ROWS rows) out of the banked
//   accumulator table and streams it row by row over a valid/ready port.
// Ports
//   clk, reset                   clock, asynchronous active-low reset
//   start, submat_m, submat_n,   drain command (sampled only when idle)
//   num_rows
//   rd_en, rd_addr, rd_data      table read side, one-cycle read latency
//   out_valid, out_ready,        row stream
//   out_data, out_row, out_last
//   busy, done                   status; done pulses once per command
module accum_table_drain
  import tpu_accum_pkg::*;
#(
  parameter  int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter  int MAX_OUT_ROWS = DEF_MAX_OUT_ROWS,
  parameter  int MAX_OUT_COLS = DEF_MAX_OUT_COLS,
  parameter  int SYS_ARR_ROWS = DEF_SYS_ARR_ROWS,
  parameter  int SYS_ARR_COLS = DEF_SYS_ARR_COLS,
  localparam int ADDR_WIDTH   = addrWidthOf(MAX_OUT_ROWS, MAX_OUT_COLS, SYS_ARR_COLS),
  localparam int MW           = blockIdxWidthOf(MAX_OUT_ROWS, SYS_ARR_ROWS),
  localparam int NW           = blockIdxWidthOf(MAX_OUT_COLS, SYS_ARR_COLS),
  localparam int RW           = rowIdxWidthOf(SYS_ARR_ROWS)
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [MW-1:0]                      submat_m,
  input  logic [NW-1:0]                      submat_n,
  input  logic [RW:0]                        num_rows,
  output logic [SYS_ARR_COLS-1:0]            rd_en,
  output logic [ADDR_WIDTH*SYS_ARR_COLS-1:0] rd_addr,
  input  logic [DATA_WIDTH*SYS_ARR_COLS-1:0] rd_data,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [DATA_WIDTH*SYS_ARR_COLS-1:0] out_data,
  output logic [RW-1:0]                      out_row,
  output logic                               out_last,
  output logic                               busy,
  output logic                               done
);

  drain_state_e    r_state;
  logic [MW-1:0]   r_m;
  logic [NW-1:0]   r_n;
  logic [RW:0]     r_rows;
  logic [RW:0]     r_issue_row;
  logic            r_inflight;
  logic [RW-1:0]   r_inflight_row;
  logic            r_inflight_last;
  logic            r_busy;
  logic            r_done;

  logic [RW:0]           w_rows_clamped;
  logic [1:0]            w_held;
  logic [2:0]            w_occupancy;
  logic                  w_pop;
  logic                  w_credit_ok;
  logic                  w_rd_fire;
  logic                  w_last_issue;
  logic [ADDR_WIDTH-1:0] w_row_addr;

  assign w_rows_clamped = (num_rows > (RW+1)'(SYS_ARR_ROWS)) ?
                          (RW+1)'(SYS_ARR_ROWS) : num_rows;

  // A read may only go out if its data is guaranteed a buffer slot when it
  // returns next cycle: rows held plus the read still in flight, minus the
  // row leaving this cycle, must leave room.
  assign w_pop       = out_valid && out_ready;
  assign w_occupancy = {1'b0, w_held} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_credit_ok = (w_occupancy < 3'd2);
  assign w_rd_fire   = (r_state == DRAIN_READ) && w_credit_ok;
  assign w_last_issue = (r_issue_row == (r_rows - (RW+1)'(1)));

  // Column-block n occupies MAX_OUT_ROWS consecutive words; row-block m is
  // an SYS_ARR_ROWS-row slice inside it. Every lane reads the same word.
  assign w_row_addr = ADDR_WIDTH'(r_n) * ADDR_WIDTH'(MAX_OUT_ROWS)
                    + ADDR_WIDTH'(r_m) * ADDR_WIDTH'(SYS_ARR_ROWS)
                    + ADDR_WIDTH'(r_issue_row[RW-1:0]);

  assign rd_en   = {SYS_ARR_COLS{w_rd_fire}};
  assign rd_addr = w_rd_fire ? {SYS_ARR_COLS{w_row_addr}} : '0;
  assign busy    = r_busy;
  assign done    = r_done;

  // Drain FSM plus row-issue counter and in-flight read tracking. The
  // in-flight tag travels with each read so the buffer receives the row
  // index and last flag alongside the returning data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= DRAIN_IDLE;
      r_m             <= '0;
      r_n             <= '0;
      r_rows          <= '0;
      r_issue_row     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_row  <= '0;
      r_inflight_last <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_inflight <= w_rd_fire;
      r_done     <= 1'b0;
      if (w_rd_fire) begin
        r_inflight_row  <= r_issue_row[RW-1:0];
        r_inflight_last <= w_last_issue;
        r_issue_row     <= r_issue_row + (RW+1)'(1);
      end
      case (r_state)
        DRAIN_IDLE: begin
          if (start) begin
            r_m         <= submat_m;
            r_n         <= submat_n;
            r_rows      <= w_rows_clamped;
            r_issue_row <= '0;
            r_busy      <= 1'b1;
            if (w_rows_clamped == '0) begin
              r_state <= DRAIN_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= DRAIN_READ;
            end
          end
        end
        DRAIN_READ: begin
          if (w_rd_fire && w_last_issue) begin
            r_state <= DRAIN_FLUSH;
          end
        end
        DRAIN_FLUSH: begin
          if (w_pop && out_last) begin
            r_state <= DRAIN_DONE;
            r_done  <= 1'b1;
          end
        end
        DRAIN_DONE: begin
          r_state <= DRAIN_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= DRAIN_IDLE;
        end
      endcase
    end
  end

  accum_drain_skid #(
    .DATA_W (DATA_WIDTH * SYS_ARR_COLS),
    .ROW_W  (RW)
  ) u_skid (
    .i_clk   (clk),
    .i_rst_n (reset),
    .i_push  (r_inflight),
    .i_data  (rd_data),
    .i_row   (r_inflight_row),
    .i_last  (r_inflight_last),
    .i_ready (out_ready),
    .o_valid (out_valid),
    .o_data  (out_data),
    .o_row   (out_row),
    .o_last  (out_last),
    .o_count (w_held)
  );

endmodule

// File: tb/tb_accum_table_drain.sv
// tb_accum_table_drain
//   Randomized bench for accum_table_drain. A behavioural table model
//   answers reads; each command pushes its expected row stream and read
//   addresses into queues that a negedge monitor pops and compares.
module tb_accum_table_drain;
  import tpu_accum_pkg::*;

  localparam int DW  = DEF_DATA_WIDTH;
  localparam int MOR = DEF_MAX_OUT_ROWS;
  localparam int MOC = DEF_MAX_OUT_COLS;
  localparam int SR  = DEF_SYS_ARR_ROWS;
  localparam int SC  = DEF_SYS_ARR_COLS;
  localparam int AW  = $clog2(MOR * (MOC / SC));
  localparam int MW  = $clog2(MOR / SR);
  localparam int NW  = $clog2(MOC / SC);
  localparam int RW  = $clog2(SR);

  typedef struct packed {
    logic [SC*DW-1:0] data;
    logic [RW-1:0]    row;
    logic             last;
  } beat_t;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic [MW-1:0]     submat_m = '0;
  logic [NW-1:0]     submat_n = '0;
  logic [RW:0]       num_rows = '0;
  logic [SC-1:0]     rd_en;
  logic [AW*SC-1:0]  rd_addr;
  logic [DW*SC-1:0]  rd_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DW*SC-1:0]  out_data;
  logic [RW-1:0]     out_row;
  logic              out_last;
  logic              busy;
  logic              done;

  logic [DW-1:0] tableMem [SC][1<<AW];

  beat_t         expQ[$];
  logic [AW-1:0] addrQ[$];

  int checkCount = 0;
  int passCount  = 0;
  int cycleCount = 0;
  int readyMode  = 0;
  int readsIssued = 0;
  int beatsPopped = 0;
  int doneCount  = 0;
  int doneBase   = 0;
  int doneCycle  = -1;
  int busyCycles = 0;
  int startCycle = 0;
  int firstRdCycle = -1;
  int firstValidCycle = -1;

  accum_table_drain dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .submat_m  (submat_m),
    .submat_n  (submat_n),
    .num_rows  (num_rows),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cycleCount++;
    end
  end

  // Table model: one-cycle read latency per lane.
  always @(posedge clk) begin
    for (int c = 0; c < SC; c++) begin
      if (rd_en[c]) rd_data[c*DW +: DW] <= tableMem[c][rd_addr[c*AW +: AW]];
    end
  end

  // Consumer backpressure: always ready, the 1,0,0,1 pattern, or random.
  initial begin
    int phase = 0;
    forever begin
      @(posedge clk);
      #1;
      case (readyMode)
        0: out_ready = 1'b1;
        1: out_ready = !((phase % 4 == 1) || (phase % 4 == 2));
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      phase++;
    end
  end

  task automatic checkOutput(input string name, input logic [255:0] actual,
                             input logic [255:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
  endtask

  // Monitor: compares reads and beats against the queues, checks hold
  // during stalls and buffer credit, and collects timing/status stats.
  initial begin
    logic          popNow;
    logic          prevStall = 1'b0;
    beat_t         prevBeat = '0;
    beat_t         expB;
    logic [AW-1:0] expA;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prevStall = 1'b0;
      end else begin
        popNow = out_valid && out_ready;
        if (rd_en != '0) begin
          checkOutput("rd_en_lanes", 256'(rd_en), 256'({SC{1'b1}}));
          if (addrQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL unexpected_read: actual=addr %0h required=no read", rd_addr[AW-1:0]);
          end else begin
            expA = addrQ.pop_front();
            checkOutput("rd_addr", 256'(rd_addr), 256'({SC{expA}}));
          end
          checkOutput("rd_credit",
                      256'((readsIssued - beatsPopped - (popNow ? 1 : 0)) < 2), 256'(1));
          readsIssued++;
          if (firstRdCycle < 0) firstRdCycle = cycleCount;
        end
        if (out_valid && firstValidCycle < 0) firstValidCycle = cycleCount;
        if (prevStall) begin
          checkOutput("stall_hold", 256'({out_valid, out_data, out_row, out_last}),
                      256'({1'b1, prevBeat}));
        end
        if (popNow) begin
          if (expQ.size() == 0) begin
            checkCount++;
            $display("[TB] FAIL unexpected_beat: actual=row %0d required=no beat", out_row);
          end else begin
            expB = expQ.pop_front();
            checkOutput("beat_data", 256'(out_data), 256'(expB.data));
            checkOutput("beat_row", 256'(out_row), 256'(expB.row));
            checkOutput("beat_last", 256'(out_last), 256'(expB.last));
          end
          beatsPopped++;
        end
        prevStall = out_valid && !out_ready;
        prevBeat  = '{data: out_data, row: out_row, last: out_last};
        if (done) begin
          doneCount++;
          doneCycle = cycleCount;
        end
        if (busy) busyCycles++;
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: actual=still running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic fillRandom();
    for (int c = 0; c < SC; c++)
      for (int a = 0; a < (1 << AW); a++)
        tableMem[c][a] = DW'($urandom);
  endtask

  // Reference model: row r of submatrix (m,n) lives at word n*MOR + m*SR + r.
  task automatic issueCommand(input int m, input int n, input int rows, input bit immediate);
    int    rowsEff;
    int    a;
    beat_t b;
    rowsEff = (rows > SR) ? SR : rows;
    for (int r = 0; r < rowsEff; r++) begin
      a = n * MOR + m * SR + r;
      for (int c = 0; c < SC; c++) b.data[c*DW +: DW] = tableMem[c][a];
      b.row  = RW'(r);
      b.last = (r == rowsEff - 1);
      expQ.push_back(b);
      addrQ.push_back(AW'(a));
    end
    if (!immediate) begin
      @(posedge clk);
      #1;
    end
    firstRdCycle    = -1;
    firstValidCycle = -1;
    busyCycles      = 0;
    doneBase        = doneCount;
    startCycle      = cycleCount;
    start    = 1'b1;
    submat_m = MW'(m);
    submat_n = NW'(n);
    num_rows = (RW+1)'(rows);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitCommand(input int rows);
    int rowsEff;
    int waited;
    rowsEff = (rows > SR) ? SR : rows;
    waited = 0;
    while (doneCount == doneBase && waited < 2000) begin
      @(posedge clk);
      waited++;
    end
    if (doneCount == doneBase) begin
      checkCount++;
      $display("[TB] FAIL done_timeout: actual=no done required=done within 2000 cycles");
    end
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_once", 256'(doneCount - doneBase), 256'(1));
    checkOutput("beats_drained", 256'(expQ.size()), 256'(0));
    checkOutput("addrs_drained", 256'(addrQ.size()), 256'(0));
    checkOutput("busy_idle", 256'(busy), 256'(0));
    if (rowsEff == 0) begin
      checkOutput("zero_no_read", 256'(firstRdCycle < 0), 256'(1));
      checkOutput("zero_no_valid", 256'(firstValidCycle < 0), 256'(1));
      checkOutput("zero_busy_cycles", 256'(busyCycles), 256'(1));
      checkOutput("zero_done_cycle", 256'(doneCycle - startCycle), 256'(1));
    end else if (readyMode == 0) begin
      checkOutput("first_rd_cycle", 256'(firstRdCycle - startCycle), 256'(1));
      checkOutput("first_valid_cycle", 256'(firstValidCycle - startCycle), 256'(3));
      checkOutput("done_cycle", 256'(doneCycle - startCycle), 256'(rowsEff + 3));
    end
  endtask

  task automatic applyStimulus(input int m, input int n, input int rows,
                               input int mode, input bit extraStart);
    readyMode = mode;
    issueCommand(m, n, rows, 1'b0);
    if (extraStart) begin
      start    = 1'b1;
      submat_m = MW'(m + 1);
      submat_n = NW'(n + 1);
      num_rows = (RW+1)'(3);
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    waitCommand(rows);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_rd_en"}, 256'(rd_en), 256'(0));
    checkOutput({tag, "_rd_addr"}, 256'(rd_addr), 256'(0));
    checkOutput({tag, "_out_valid"}, 256'(out_valid), 256'(0));
    checkOutput({tag, "_out_last"}, 256'(out_last), 256'(0));
    checkOutput({tag, "_out_row"}, 256'(out_row), 256'(0));
    checkOutput({tag, "_out_data"}, 256'(out_data), 256'(0));
    checkOutput({tag, "_busy"}, 256'(busy), 256'(0));
    checkOutput({tag, "_done"}, 256'(done), 256'(0));
  endtask

  initial begin
    int base;
    int waited;
    fillRandom();
    #1;
    checkResetOutputs("reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Rows hold r+1 in every lane of submatrix (0,0).
    for (int r = 0; r < SR; r++)
      for (int c = 0; c < SC; c++) tableMem[c][r] = DW'(r + 1);
    $display("[TB] full drain of submatrix (0,0)");
    applyStimulus(0, 0, 16, 0, 1'b0);

    $display("[TB] submatrix (2,3), 4 rows");
    applyStimulus(2, 3, 4, 0, 1'b0);

    $display("[TB] backpressure pattern 1,0,0,1");
    applyStimulus(5, 1, 16, 1, 1'b0);

    $display("[TB] zero-row command");
    applyStimulus(4, 6, 0, 0, 1'b0);

    $display("[TB] second start while busy");
    applyStimulus(3, 2, 10, 0, 1'b1);

    $display("[TB] reset in the middle of a drain");
    readyMode = 0;
    base = beatsPopped;
    issueCommand(1, 2, 16, 1'b0);
    waited = 0;
    while ((beatsPopped - base) < 7 && waited < 200) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if ((beatsPopped - base) < 7) begin
      checkCount++;
      $display("[TB] FAIL reset_wait_timeout: actual=%0d beats required=7", beatsPopped - base);
    end
    reset = 1'b0;
    #1;
    checkResetOutputs("midreset");
    expQ.delete();
    addrQ.delete();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no_done_after_reset", 256'(doneCount - doneBase), 256'(0));
    readsIssued = 0;
    beatsPopped = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    issueCommand(6, 4, 12, 1'b1);
    waitCommand(12);

    $display("[TB] oversized row count");
    applyStimulus(7, 7, 20, 0, 1'b0);

    $display("[TB] random commands");
    for (int i = 0; i < 10; i++) begin
      fillRandom();
      applyStimulus(int'($urandom_range(0, (1 << MW) - 1)),
                    int'($urandom_range(0, (1 << NW) - 1)),
                    int'($urandom_range(0, 20)),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
